// File: rtl/fft16_pt.sv
// Self-running 16-point radix-2 DIT FFT over a fixed ramp ROM (x[n] = n).
// One butterfly per clock; operands, rotated operand, twiddle and results are registered out.
//   state     | meaning
//   S_LOAD    | 16 cycles: ROM[i] -> RAM[bitrev(i)], outputs held at 0
//   S_COMPUTE | 32 cycles: 4 stages x 8 butterflies, RAM updated in place
//   S_OUT     | 8 cycles: z1 = X[k], z2 = X[k+8]
//   S_IDLE    | outputs frozen until reset
module fft16_pt #(
  parameter int DW = 24,
  parameter int TW = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic signed [DW-1:0] x1_r,
  output logic signed [DW-1:0] x1_c,
  output logic signed [DW-1:0] x2_r,
  output logic signed [DW-1:0] x2_c,
  output logic signed [DW-1:0] y1_r,
  output logic signed [DW-1:0] y1_c,
  output logic signed [DW-1:0] y2_r,
  output logic signed [DW-1:0] y2_c,
  output logic signed [TW-1:0] ra1_r,
  output logic signed [TW-1:0] ra1_c,
  output logic signed [DW-1:0] z1_r,
  output logic signed [DW-1:0] z1_c,
  output logic signed [DW-1:0] z2_r,
  output logic signed [DW-1:0] z2_c
);

  localparam int PW = DW + TW + 1;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUT, S_IDLE} state_t;

  state_t               r_state;
  logic [4:0]           r_tmr;
  logic signed [DW-1:0] r_ram_r [16];
  logic signed [DW-1:0] r_ram_i [16];

  logic [4:0]           w_idx;
  logic [3:0]           w_lda;
  logic [3:0]           w_top;
  logic [3:0]           w_bot;
  logic [2:0]           w_m;
  logic signed [TW-1:0] w_wr;
  logic signed [TW-1:0] w_wi;
  logic signed [DW-1:0] w_ar;
  logic signed [DW-1:0] w_ai;
  logic signed [DW-1:0] w_br;
  logic signed [DW-1:0] w_bi;
  logic signed [PW-1:0] w_pr_full;
  logic signed [PW-1:0] w_pi_full;
  logic signed [DW-1:0] w_pr;
  logic signed [DW-1:0] w_pi;

  // Down-counter counts to terminal 0; its complement is the step index within the phase.
  assign w_idx = ~r_tmr;
  assign w_lda = {w_idx[0], w_idx[1], w_idx[2], w_idx[3]};

  always_comb begin
    w_top = '0;
    w_bot = '0;
    w_m   = '0;
    case (w_idx[4:3])
      2'd0: begin
        w_top = {w_idx[2:0], 1'b0};
        w_bot = {w_idx[2:0], 1'b1};
        w_m   = 3'd0;
      end
      2'd1: begin
        w_top = {w_idx[2:1], 1'b0, w_idx[0]};
        w_bot = {w_idx[2:1], 1'b1, w_idx[0]};
        w_m   = {w_idx[0], 2'b00};
      end
      2'd2: begin
        w_top = {w_idx[2], 1'b0, w_idx[1:0]};
        w_bot = {w_idx[2], 1'b1, w_idx[1:0]};
        w_m   = {w_idx[1:0], 1'b0};
      end
      default: begin
        w_top = {1'b0, w_idx[2:0]};
        w_bot = {1'b1, w_idx[2:0]};
        w_m   = w_idx[2:0];
      end
    endcase
  end

  // W^m = cos - j*sin, Q1.12
  always_comb begin
    w_wr = '0;
    w_wi = '0;
    case (w_m)
      3'd0: begin w_wr =  14'sd4096; w_wi =  14'sd0;    end
      3'd1: begin w_wr =  14'sd3784; w_wi = -14'sd1567; end
      3'd2: begin w_wr =  14'sd2896; w_wi = -14'sd2896; end
      3'd3: begin w_wr =  14'sd1567; w_wi = -14'sd3784; end
      3'd4: begin w_wr =  14'sd0;    w_wi = -14'sd4096; end
      3'd5: begin w_wr = -14'sd1567; w_wi = -14'sd3784; end
      3'd6: begin w_wr = -14'sd2896; w_wi = -14'sd2896; end
      default: begin w_wr = -14'sd3784; w_wi = -14'sd1567; end
    endcase
  end

  assign w_ar = r_ram_r[w_top];
  assign w_ai = r_ram_i[w_top];
  assign w_br = r_ram_r[w_bot];
  assign w_bi = r_ram_i[w_bot];

  assign w_pr_full = PW'(w_wr) * PW'(w_br) - PW'(w_wi) * PW'(w_bi);
  assign w_pi_full = PW'(w_wr) * PW'(w_bi) + PW'(w_wi) * PW'(w_br);
  assign w_pr      = DW'(w_pr_full >>> 12);
  assign w_pi      = DW'(w_pi_full >>> 12);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_tmr   <= 5'd15;
      x1_r <= '0; x1_c <= '0; x2_r <= '0; x2_c <= '0;
      y1_r <= '0; y1_c <= '0; y2_r <= '0; y2_c <= '0;
      ra1_r <= '0; ra1_c <= '0;
      z1_r <= '0; z1_c <= '0; z2_r <= '0; z2_c <= '0;
      for (int i = 0; i < 16; i++) begin
        r_ram_r[i] <= '0;
        r_ram_i[i] <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          r_ram_r[w_lda] <= {{(DW-4){1'b0}}, w_idx[3:0]};
          r_ram_i[w_lda] <= '0;
          if (r_tmr == 5'd0) begin
            r_state <= S_COMPUTE;
            r_tmr   <= 5'd31;
          end else begin
            r_tmr <= r_tmr - 5'd1;
          end
        end
        S_COMPUTE: begin
          r_ram_r[w_top] <= w_ar + w_pr;
          r_ram_i[w_top] <= w_ai + w_pi;
          r_ram_r[w_bot] <= w_ar - w_pr;
          r_ram_i[w_bot] <= w_ai - w_pi;
          x1_r <= w_ar; x1_c <= w_ai; x2_r <= w_br; x2_c <= w_bi;
          y1_r <= w_pr; y1_c <= w_pi; y2_r <= -w_pr; y2_c <= -w_pi;
          ra1_r <= w_wr; ra1_c <= w_wi;
          z1_r <= w_ar + w_pr; z1_c <= w_ai + w_pi;
          z2_r <= w_ar - w_pr; z2_c <= w_ai - w_pi;
          if (r_tmr == 5'd0) begin
            r_state <= S_OUT;
            r_tmr   <= 5'd7;
          end else begin
            r_tmr <= r_tmr - 5'd1;
          end
        end
        S_OUT: begin
          x1_r <= '0; x1_c <= '0; x2_r <= '0; x2_c <= '0;
          y1_r <= '0; y1_c <= '0; y2_r <= '0; y2_c <= '0;
          ra1_r <= '0; ra1_c <= '0;
          z1_r <= r_ram_r[{1'b0, w_idx[2:0]}];
          z1_c <= r_ram_i[{1'b0, w_idx[2:0]}];
          z2_r <= r_ram_r[{1'b1, w_idx[2:0]}];
          z2_c <= r_ram_i[{1'b1, w_idx[2:0]}];
          if (r_tmr == 5'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr - 5'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_pt.sv
// Bench for fft16_pt: integer FFT model plus floating-point DFT reference,
// randomized mid-run reset points and reset hold lengths.
module tb_fft16_pt;

  localparam int DW = 24;
  localparam int TW = 14;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [DW-1:0] x1_r, x1_c, x2_r, x2_c;
  logic signed [DW-1:0] y1_r, y1_c, y2_r, y2_c;
  logic signed [TW-1:0] ra1_r, ra1_c;
  logic signed [DW-1:0] z1_r, z1_c, z2_r, z2_c;
  logic [12*DW+2*TW-1:0] all_out;

  fft16_pt #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .x1_r(x1_r), .x1_c(x1_c), .x2_r(x2_r), .x2_c(x2_c),
    .y1_r(y1_r), .y1_c(y1_c), .y2_r(y2_r), .y2_c(y2_c),
    .ra1_r(ra1_r), .ra1_c(ra1_c),
    .z1_r(z1_r), .z1_c(z1_c), .z2_r(z2_r), .z2_c(z2_c)
  );

  assign all_out = {x1_r, x1_c, x2_r, x2_c, y1_r, y1_c, y2_r, y2_c,
                    ra1_r, ra1_c, z1_r, z1_c, z2_r, z2_c};

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int ar, ai, br, bi, wr, wi, pr, pi;
  } bfly_t;

  bfly_t exp_bf[32];
  int    bin_r[16];
  int    bin_i[16];
  real   ref_r[16];
  real   ref_i[16];

  function automatic int rnd(real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int bitrev(int i);
    return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
  endfunction

  // Textbook in-place DIT over plain arrays, plus a direct DFT sum in reals.
  task automatic build_model;
    int dr[16];
    int di[16];
    int b;
    b = 0;
    for (int n = 0; n < 16; n++) begin
      dr[bitrev(n)] = n;
      di[bitrev(n)] = 0;
    end
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 8; j++) begin
        int h, top, bot, m;
        longint pr, pi;
        real ang;
        h   = 1 << s;
        top = (j >> s) * 2 * h + (j & (h - 1));
        bot = top + h;
        m   = (j & (h - 1)) * (8 >> s);
        ang = 2.0 * PI * real'(m) / 16.0;
        exp_bf[b].wr = rnd(4096.0 * $cos(ang));
        exp_bf[b].wi = -rnd(4096.0 * $sin(ang));
        pr = (longint'(exp_bf[b].wr) * dr[bot] - longint'(exp_bf[b].wi) * di[bot]) >>> 12;
        pi = (longint'(exp_bf[b].wr) * di[bot] + longint'(exp_bf[b].wi) * dr[bot]) >>> 12;
        exp_bf[b].ar = dr[top];
        exp_bf[b].ai = di[top];
        exp_bf[b].br = dr[bot];
        exp_bf[b].bi = di[bot];
        exp_bf[b].pr = int'(pr);
        exp_bf[b].pi = int'(pi);
        dr[top] = exp_bf[b].ar + int'(pr);
        di[top] = exp_bf[b].ai + int'(pi);
        dr[bot] = exp_bf[b].ar - int'(pr);
        di[bot] = exp_bf[b].ai - int'(pi);
        b++;
      end
    end
    for (int k = 0; k < 16; k++) begin
      bin_r[k] = dr[k];
      bin_i[k] = di[k];
      ref_r[k] = 0.0;
      ref_i[k] = 0.0;
      for (int n = 0; n < 16; n++) begin
        ref_r[k] = ref_r[k] + real'(n) * $cos(2.0 * PI * real'(k * n) / 16.0);
        ref_i[k] = ref_i[k] - real'(n) * $sin(2.0 * PI * real'(k * n) / 16.0);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input int hold);
    rst = 1'b1;
    for (int c = 0; c < hold; c++) begin
      tick;
      n_vec++;
      if (all_out !== '0) begin
        n_err++;
        $display("FAIL reset_zero cycle %0d: got %h want 0", c, all_out);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick;
      n_vec++;
      if (all_out !== '0) begin
        n_err++;
        $display("FAIL load_zero cycle %0d: got %h want 0", c, all_out);
      end
    end
  endtask

  task automatic test_compute;
    for (int b = 0; b < 32; b++) begin
      bfly_t e;
      tick;
      e = exp_bf[b];
      n_vec++;
      if ({x1_r, x1_c, x2_r, x2_c} !== {DW'(e.ar), DW'(e.ai), DW'(e.br), DW'(e.bi)}) begin
        n_err++;
        $display("FAIL bfly%0d_x: got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", b,
                 x1_r, x1_c, x2_r, x2_c, e.ar, e.ai, e.br, e.bi);
      end
      n_vec++;
      if ({ra1_r, ra1_c} !== {TW'(e.wr), TW'(e.wi)}) begin
        n_err++;
        $display("FAIL bfly%0d_ra1: got %0d,%0d want %0d,%0d", b, ra1_r, ra1_c, e.wr, e.wi);
      end
      n_vec++;
      if ({y1_r, y1_c, y2_r, y2_c} !== {DW'(e.pr), DW'(e.pi), DW'(-e.pr), DW'(-e.pi)}) begin
        n_err++;
        $display("FAIL bfly%0d_y: got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", b,
                 y1_r, y1_c, y2_r, y2_c, e.pr, e.pi, -e.pr, -e.pi);
      end
      n_vec++;
      if ({z1_r, z1_c, z2_r, z2_c} !==
          {DW'(e.ar + e.pr), DW'(e.ai + e.pi), DW'(e.ar - e.pr), DW'(e.ai - e.pi)}) begin
        n_err++;
        $display("FAIL bfly%0d_z: got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", b,
                 z1_r, z1_c, z2_r, z2_c, e.ar + e.pr, e.ai + e.pi, e.ar - e.pr, e.ai - e.pi);
      end
      if (b == 0) begin
        n_vec++;
        if (int'(x1_r) != 0 || int'(x2_r) != 8 || int'(ra1_r) != 4096 || int'(ra1_c) != 0 ||
            int'(y1_r) != 8 || int'(y2_r) != -8 || int'(z1_r) != 8 || int'(z2_r) != -8) begin
          n_err++;
          $display("FAIL first_bfly: got x1=%0d x2=%0d ra1=%0d,%0d y1=%0d y2=%0d z1=%0d z2=%0d want 0 8 4096,0 8 -8 8 -8",
                   x1_r, x2_r, ra1_r, ra1_c, y1_r, y2_r, z1_r, z2_r);
        end
      end
      if (b == 9) begin
        n_vec++;
        if (int'(ra1_r) != 0 || int'(ra1_c) != -4096 ||
            int'(y1_r) != e.bi || int'(y1_c) != -e.br) begin
          n_err++;
          $display("FAIL m4_rotate: got ra1=%0d,%0d y1=%0d,%0d want 0,-4096 %0d,%0d",
                   ra1_r, ra1_c, y1_r, y1_c, e.bi, -e.br);
        end
      end
    end
  endtask

  task automatic test_out;
    for (int k = 0; k < 8; k++) begin
      real d [4];
      tick;
      n_vec++;
      if ({z1_r, z1_c, z2_r, z2_c} !==
          {DW'(bin_r[k]), DW'(bin_i[k]), DW'(bin_r[k+8]), DW'(bin_i[k+8])}) begin
        n_err++;
        $display("FAIL out%0d_bins: got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", k,
                 z1_r, z1_c, z2_r, z2_c, bin_r[k], bin_i[k], bin_r[k+8], bin_i[k+8]);
      end
      n_vec++;
      if ({x1_r, x1_c, x2_r, x2_c, y1_r, y1_c, y2_r, y2_c, ra1_r, ra1_c} !== '0) begin
        n_err++;
        $display("FAIL out%0d_xy_zero: got %0d,%0d,%0d,%0d y %0d,%0d ra1 %0d,%0d want 0", k,
                 x1_r, x1_c, x2_r, x2_c, y1_r, y1_c, ra1_r, ra1_c);
      end
      d[0] = real'(int'(z1_r)) - ref_r[k];
      d[1] = real'(int'(z1_c)) - ref_i[k];
      d[2] = real'(int'(z2_r)) - ref_r[k+8];
      d[3] = real'(int'(z2_c)) - ref_i[k+8];
      n_vec++;
      if (d[0] > 4.0 || d[0] < -4.0 || d[1] > 4.0 || d[1] < -4.0 ||
          d[2] > 4.0 || d[2] < -4.0 || d[3] > 4.0 || d[3] < -4.0) begin
        n_err++;
        $display("FAIL out%0d_float: got %0d,%0d,%0d,%0d want %f,%f,%f,%f +/-4", k,
                 z1_r, z1_c, z2_r, z2_c, ref_r[k], ref_i[k], ref_r[k+8], ref_i[k+8]);
      end
      if (k == 0) begin
        n_vec++;
        if (int'(z1_r) != 120 || int'(z1_c) != 0 || int'(z2_r) != -8 || int'(z2_c) != 0) begin
          n_err++;
          $display("FAIL bin0_8: got %0d,%0d %0d,%0d want 120,0 -8,0", z1_r, z1_c, z2_r, z2_c);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (int'(z1_r) < -10 || int'(z1_r) > -6 || int'(z1_c) < 6 || int'(z1_c) > 10 ||
            int'(z2_r) < -10 || int'(z2_r) > -6 || int'(z2_c) < -10 || int'(z2_c) > -6) begin
          n_err++;
          $display("FAIL bin4_12: got %0d,%0d %0d,%0d want -8,8 -8,-8 +/-2", z1_r, z1_c, z2_r, z2_c);
        end
      end
    end
  endtask

  task automatic test_idle;
    for (int c = 0; c < 100; c++) begin
      tick;
      n_vec++;
      if (all_out !== {{(10*DW+2*TW){1'b0}}, DW'(bin_r[7]), DW'(bin_i[7]),
                       DW'(bin_r[15]), DW'(bin_i[15])}) begin
        n_err++;
        $display("FAIL idle_hold cycle %0d: got z %0d,%0d %0d,%0d want %0d,%0d %0d,%0d", c,
                 z1_r, z1_c, z2_r, z2_c, bin_r[7], bin_i[7], bin_r[15], bin_i[15]);
      end
    end
  endtask

  task automatic test_mid_reset(input int run);
    for (int c = 0; c < run; c++) tick;
    test_reset(1);
    test_compute;
    test_out;
  endtask

  initial begin
    build_model;
    test_reset(5);
    test_compute;
    test_out;
    test_idle;
    for (int r = 0; r < 3; r++) begin
      test_reset(int'($urandom_range(1, 6)));
      test_mid_reset(int'($urandom_range(1, 31)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
